// File: rtl/mw_add_pkg.sv
// Shared constants and state encoding for the multi-word addition sequencer
// and the registered 32-bit adder stage it drives.
package mw_add_pkg;

  localparam int LIMB_W      = 32;
  localparam int CLA_LATENCY = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_COLLECT = 3'd3,
    S_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/cla_clk.sv
// Registered 32-bit carry-lookahead adder: inputs and result each pass a register,
// so a limb driven in cycle t shows up on s/co in cycle t+2. No reset by design.
module cla_clk
  import mw_add_pkg::*;
(
  input  logic              clock,
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              ci,
  output logic [LIMB_W-1:0] s,
  output logic              co
);

  logic [LIMB_W-1:0] a_p0, b_p0;
  logic              ci_p0;
  logic [LIMB_W-1:0] s_p1;
  logic              co_p1;
  logic [LIMB_W-1:0] gen, prp;
  logic [LIMB_W:0]   carry;

  // stage p0: capture operands
  always_ff @(posedge clock) begin
    a_p0  <= a;
    b_p0  <= b;
    ci_p0 <= ci;
  end

  always_comb begin
    gen      = a_p0 & b_p0;
    prp      = a_p0 ^ b_p0;
    carry    = '0;
    carry[0] = ci_p0;
    for (int i = 0; i < LIMB_W; i++) begin
      carry[i+1] = gen[i] | (prp[i] & carry[i]);
    end
  end

  // stage p1: registered sum and carry-out
  always_ff @(posedge clock) begin
    s_p1  <= prp ^ carry[LIMB_W-1:0];
    co_p1 <= carry[LIMB_W];
  end

  assign s  = s_p1;
  assign co = co_p1;

endmodule

// File: rtl/mw_add_top.sv
// Thin wrapper pairing the sequencer with its registered 32-bit adder stage.
module mw_add_top
  import mw_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LIMB_W*WORDS-1:0] op_a,
  input  logic [LIMB_W*WORDS-1:0] op_b,
  input  logic                    ci,
  output logic                    busy,
  output logic                    done,
  output logic [LIMB_W*WORDS-1:0] sum,
  output logic                    co
);

  logic [LIMB_W-1:0] cla_a, cla_b, cla_s;
  logic              cla_ci, cla_co;

  mw_add_seq #(.WORDS(WORDS)) u_seq (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .ci     (ci),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .co     (co),
    .cla_a  (cla_a),
    .cla_b  (cla_b),
    .cla_ci (cla_ci),
    .cla_s  (cla_s),
    .cla_co (cla_co)
  );

  cla_clk u_cla (
    .clock (clock),
    .a     (cla_a),
    .b     (cla_b),
    .ci    (cla_ci),
    .s     (cla_s),
    .co    (cla_co)
  );

endmodule

// File: rtl/mw_add_seq.sv
// Multi-word addition sequencer: feeds 32-bit limbs through the registered adder
// stage one at a time, chaining the carry, to build a 32*WORDS-bit adder.
module mw_add_seq
  import mw_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LIMB_W*WORDS-1:0]  op_a,
  input  logic [LIMB_W*WORDS-1:0]  op_b,
  input  logic                     ci,
  output logic                     busy,
  output logic                     done,
  output logic [LIMB_W*WORDS-1:0]  sum,
  output logic                     co,
  output logic [LIMB_W-1:0]        cla_a,
  output logic [LIMB_W-1:0]        cla_b,
  output logic                     cla_ci,
  input  logic [LIMB_W-1:0]        cla_s,
  input  logic                     cla_co
);

  localparam int W         = LIMB_W * WORDS;
  localparam int IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WAIT_CYC  = (CLA_LATENCY > 1) ? CLA_LATENCY - 1 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
  localparam logic [3:0]       LAST_WAIT = 4'(WAIT_CYC - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     opa_q, opa_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       wcnt_q, wcnt_d;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    co_d    = co_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = op_a;
          opb_d   = op_b;
          carry_d = ci;
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      // WAIT spans the adder latency so COLLECT lands exactly on the limb result
      S_WAIT: begin
        if (wcnt_q == LAST_WAIT) begin
          state_d = S_COLLECT;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      S_COLLECT: begin
        sum_d[idx_q*LIMB_W +: LIMB_W] = cla_s;
        carry_d = cla_co;
        if (idx_q == LAST_IDX) begin
          co_d    = cla_co;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      idx_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    cla_a  = '0;
    cla_b  = '0;
    cla_ci = 1'b0;
    if (state_q == S_ISSUE) begin
      cla_a  = opa_q[idx_q*LIMB_W +: LIMB_W];
      cla_b  = opb_q[idx_q*LIMB_W +: LIMB_W];
      cla_ci = carry_q;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign co   = co_q;

endmodule

// File: doc/mw_add_seq.md
# mw_add_seq

Multi-word addition sequencer that sits on both sides of the registered 32-bit carry-lookahead adder stage (`cla_clk`). Upstream, it slices a wide operand pair into 32-bit limbs and drives them into the adder with the correct carry-in. Downstream, it collects each registered limb sum and carry-out and chains the carry into the next limb. It turns the fixed 32-bit adder into a `32*WORDS`-bit adder with a start/done handshake.

## Interface
- `WORDS`, default 4: number of 32-bit limbs; total operand width is `32*WORDS`; legal range 1–16.
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request an addition; sampled only in IDLE.
- `op_a`, in, 32*WORDS: operand A; limb i is bits `[32i+31:32i]`.
- `op_b`, in, 32*WORDS: operand B, same limb layout.
- `ci`, in, 1: carry into limb 0.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse; `sum` and `co` are valid from this cycle on.
- `sum`, out, 32*WORDS: result; held until the next accepted `start`.
- `co`, out, 1: carry out of limb `WORDS-1`; held with `sum`.
- `cla_a`, out, 32: limb A to the adder stage.
- `cla_b`, out, 32: limb B to the adder stage.
- `cla_ci`, out, 1: limb carry-in to the adder stage.
- `cla_s`, in, 32: registered limb sum from the adder stage.
- `cla_co`, in, 1: registered limb carry-out from the adder stage.

## Operation
- The adder stage latency is 2 edges. A limb driven during cycle t appears on `cla_s`/`cla_co` during cycle t+2.
- The adder stage has no reset. The FSM never samples `cla_s`/`cla_co` earlier than 2 edges after driving that limb, so values present at reset are never used.
- FSM states: IDLE, ISSUE, WAIT, COLLECT, DONE.
- **IDLE**: on `start`=1, latch `op_a`, `op_b` into operand registers. Set carry register = `ci` and limb index `idx` = 0. Go to ISSUE.
- **ISSUE**: drive `cla_a`/`cla_b` = latched limb `idx` and `cla_ci` = carry register. Go to WAIT.
- **WAIT**: no action. Go to COLLECT.
- **COLLECT**: write `cla_s` into `sum` limb `idx` and `cla_co` into the carry register.
  - If `idx` = `WORDS-1`: copy `cla_co` into `co` and go to DONE.
  - Otherwise: `idx` increments and the FSM goes to ISSUE.
- **DONE**: `done`=1 for this cycle only. Go to IDLE.
- Outside ISSUE, `cla_a`, `cla_b` and `cla_ci` are driven to 0. They are combinational from the state, `idx` and the operand registers.
- `start` is ignored whenever `busy`=1, including the DONE cycle. No queuing.
- Carry chaining is exact: `sum`/`co` equal `op_a + op_b + ci` modulo `2^(32*WORDS)`, with `co` the bit `32*WORDS` of that sum. Operand changes after acceptance have no effect.
- Reset values: state=IDLE, `busy`=0, `done`=0, `sum`=0, `co`=0, `idx`=0, carry register=0, `cla_a`=`cla_b`=0, `cla_ci`=0.
- Reset mid-operation aborts immediately: no `done`, `sum` cleared. The next `start` after reset deassertion is accepted normally.

## Timing
- `start` is accepted at edge E0. Limb i occupies ISSUE at cycle 1+3i, WAIT at 2+3i and COLLECT at 3+3i.
- `done` is high in cycle `3*WORDS+1` (13 for `WORDS`=4). `busy` is high in cycles 1 through `3*WORDS+1`.
- The earliest next `start` acceptance is the cycle after `done`, when the FSM is in IDLE.
- Throughput: one `32*WORDS`-bit addition per `3*WORDS+2` cycles.
- `sum` limb i updates at the end of cycle 3+3i. Partial sums are visible while `busy`; consumers use `sum` only from `done` onward.

## Structure
- Shared package `mw_add_pkg` holds:
  - `LIMB_W` = 32;
  - `CLA_LATENCY` = 2, used to size the WAIT phase;
  - the state enum {IDLE, ISSUE, WAIT, COLLECT, DONE}.
- `mw_add_seq` contains no sub-modules.
- A thin top `mw_add_top` instantiates `mw_add_seq` and `cla_clk` and wires them together. It exposes only `clock`, `reset`, `start`, `op_a`, `op_b`, `ci`, `busy`, `done`, `sum` and `co`.

## Test plan
All scenarios run on `mw_add_top` with `WORDS`=4.
- **Full carry ripple**: `op_a`=all ones, `op_b`=1, `ci`=0 → `sum`=0, `co`=1; `done` in cycle 13 after acceptance; `busy` high in cycles 1–13.
- **Carry-in only**: `op_a`=`op_b`=0, `ci`=1 → `sum`=1, `co`=0.
- **Limb-boundary carries**: `op_a`=0x00000001_FFFFFFFF_00000000_FFFFFFFF, `op_b`=0x00000000_00000001_00000000_00000001, `ci`=0 → `sum`=0x00000002_00000000_00000001_00000000, `co`=0.
- **Start while busy**: pulse `start` with new operands in cycles 5 and 13 (DONE) → both ignored; result equals the first operation's; the second request issued after IDLE completes correctly.
- **Reset mid-operation**: assert `reset` during WAIT of limb 2 → `busy`, `done`, `sum` and `co` go to 0 asynchronously; no `done` pulse; a following `start` with 3+4 gives `sum`=7 in cycle 13.
- **Random**: 500 random operand/`ci` triples against a reference model → `sum`/`co` match every time; `done` is exactly one cycle wide.
